pll_lock_sequencer: RTL

- Sequences the team's PLL (`ToplvlModule`) from power-up to lock.
- Holds the PLL in reset for a fixed interval, then measures the reference period.
- Enables the PLL's `Sample` input and declares lock once the feedback clock period matches the reference period for a programmable run of periods.
- Sits beside the PLL on the system clock, drives its `Reset` and `Sample` pins, and reports lock/fault status upward.

---
 rtl/pll_lock_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// Power-up sequencer for the PLL: holds it in reset, measures the reference
// period, then enables sampling and declares lock once the feedback period tracks it.
module pll_lock_sequencer #(
    parameter int CNT_W        = 8,
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_COUNT   = 8,
    parameter int TOL          = 2,
    parameter int TIMEOUT      = 200
) (
    input  logic             ClockIn,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             RefIn,
    input  logic             FbIn,
    output logic             PllReset,
    output logic             Sample,
    output logic             Locked,
    output logic             Fault,
    output logic [CNT_W-1:0] RefPeriod,
    output logic [2:0]       State
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET_PLL = 3'd1,
        S_MEASURE   = 3'd2,
        S_TRACK     = 3'd3,
        S_LOCKED    = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [RW-1:0]         RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [MW-1:0]         MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]      TIMEOUT_V  = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W:0] TOL_S      = (CNT_W + 1)'(TOL);

    state_t           state_q, state_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic [1:0]       miss_q, miss_d;
    logic [CNT_W-1:0] ref_period_q, ref_period_d;
    logic             ref_armed_q, ref_armed_d;
    logic             fb_armed_q, fb_armed_d;
    logic             pll_reset_q, sample_q, locked_q, fault_q;

    // Channel 0 = reference, channel 1 = feedback
    logic [1:0]       raw_in;
    logic [1:0]       edge_pls;
    logic [1:0]       cnt_run;
    logic [CNT_W-1:0] per_cnt [2];

    assign raw_in  = {FbIn, RefIn};
    // Counters idle at 1 outside their active states so timeouts start from state entry
    assign cnt_run[0] = (state_q == S_MEASURE) || (state_q == S_TRACK) || (state_q == S_LOCKED);
    assign cnt_run[1] = (state_q == S_TRACK) || (state_q == S_LOCKED);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             sync1_q, sync2_q, hist_q;
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge ClockIn) begin
                if (Reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    hist_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_in[gi];
                    sync2_q <= sync1_q;
                    hist_q  <= sync2_q;
                    if (!cnt_run[gi] || edge_pls[gi]) begin
                        cnt_q <= CNT_W'(1);
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end

            assign edge_pls[gi] = sync2_q & ~hist_q;
            assign per_cnt[gi]  = cnt_q;
        end
    endgenerate

    logic                 ref_pls, fb_pls, ref_timeout, fb_timeout, fb_match;
    logic signed [CNT_W:0] fb_diff;

    assign ref_pls     = edge_pls[0];
    assign fb_pls      = edge_pls[1];
    assign ref_timeout = per_cnt[0] >= TIMEOUT_V;
    assign fb_timeout  = per_cnt[1] >= TIMEOUT_V;
    assign fb_diff     = $signed({1'b0, per_cnt[1]}) - $signed({1'b0, ref_period_q});
    assign fb_match    = (fb_diff >= -TOL_S) && (fb_diff <= TOL_S) && (per_cnt[1] != CNT_MAX);

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        match_d      = match_q;
        miss_d       = miss_q;
        ref_period_d = ref_period_q;
        ref_armed_d  = ref_armed_q;
        fb_armed_d   = fb_armed_q;

        if (!Enable) begin
            state_d     = S_IDLE;
            match_d     = '0;
            miss_d      = '0;
            ref_armed_d = 1'b0;
            fb_armed_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_RESET_PLL;
                    rst_cnt_d   = '0;
                    ref_armed_d = 1'b0;
                end
                S_RESET_PLL: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d = S_MEASURE;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                S_MEASURE: begin
                    if (ref_timeout) begin
                        state_d = S_FAULT;
                    end else if (ref_pls) begin
                        if (ref_armed_q) begin
                            ref_period_d = per_cnt[0];
                            state_d      = S_TRACK;
                            match_d      = '0;
                            miss_d       = '0;
                            fb_armed_d   = 1'b0;
                        end else begin
                            ref_armed_d = 1'b1;
                        end
                    end
                end
                S_TRACK: begin
                    if (ref_pls) begin
                        ref_period_d = per_cnt[0];
                    end
                    if (ref_timeout || fb_timeout) begin
                        state_d = S_FAULT;
                    end else if (fb_pls) begin
                        // First fb edge after MEASURE has no valid period behind it
                        if (!fb_armed_q) begin
                            fb_armed_d = 1'b1;
                        end else if (fb_match) begin
                            match_d = match_q + MW'(1);
                            if (match_q == MATCH_LAST) begin
                                state_d = S_LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (ref_pls) begin
                        ref_period_d = per_cnt[0];
                    end
                    if (ref_timeout || fb_timeout) begin
                        state_d = S_FAULT;
                    end else if (fb_pls) begin
                        if (fb_match) begin
                            miss_d = '0;
                        end else if (miss_q == 2'd1) begin
                            state_d = S_TRACK;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 2'd1;
                        end
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Status pins are decoded from the next state so they move with the state register
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            match_q      <= '0;
            miss_q       <= '0;
            ref_period_q <= '0;
            ref_armed_q  <= 1'b0;
            fb_armed_q   <= 1'b0;
            pll_reset_q  <= 1'b1;
            sample_q     <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            ref_period_q <= ref_period_d;
            ref_armed_q  <= ref_armed_d;
            fb_armed_q   <= fb_armed_d;
            pll_reset_q  <= (state_d == S_IDLE) || (state_d == S_RESET_PLL) || (state_d == S_FAULT);
            sample_q     <= (state_d == S_TRACK) || (state_d == S_LOCKED);
            locked_q     <= (state_d == S_LOCKED);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign PllReset  = pll_reset_q;
    assign Sample    = sample_q;
    assign Locked    = locked_q;
    assign Fault     = fault_q;
    assign RefPeriod = ref_period_q;
    assign State     = state_q;

endmodule
